// File: rtl/iter_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide/accumulate unit:
// operation codes, FSM states and handshake levels.
package iter_muldiv_pkg;

  localparam logic [2:0] MD_MULTU = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_MADDU = 3'b100;
  localparam logic [2:0] MD_MADD  = 3'b101;
  localparam logic [2:0] MD_MSUBU = 3'b110;
  localparam logic [2:0] MD_MSUB  = 3'b111;

  localparam logic [1:0] MD_IDLE = 2'b00;
  localparam logic [1:0] MD_CALC = 2'b01;
  localparam logic [1:0] MD_FIX  = 2'b10;
  localparam logic [1:0] MD_DONE = 2'b11;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op == MD_MADDU) || (op == MD_MADD) || (op == MD_MSUBU) || (op == MD_MSUB);
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return (op == MD_MSUBU) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/iter_muldiv_sign_fix.sv
// Final-cycle correction: restores operand signs on the unsigned result and
// folds in the HI/LO accumulator for MADD/MSUB.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] val_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic               div_i,
  input  logic               neg_lo_i,
  input  logic               neg_hi_i,
  input  logic               acc_en_i,
  input  logic               sub_i,
  output logic [2*WIDTH-1:0] result_o
);

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quot_fix;

  // For divides neg_lo_i flips the quotient and neg_hi_i the remainder;
  // for multiplies neg_lo_i flips the whole product.
  assign prod     = neg_lo_i ? (~val_i + ONE_2W) : val_i;
  assign rem_fix  = neg_hi_i ? (~val_i[2*WIDTH-1:WIDTH] + ONE_W) : val_i[2*WIDTH-1:WIDTH];
  assign quot_fix = neg_lo_i ? (~val_i[WIDTH-1:0] + ONE_W) : val_i[WIDTH-1:0];

  always_comb begin
    result_o = prod;
    if (div_i) begin
      result_o = {rem_fix, quot_fix};
    end else if (acc_en_i) begin
      result_o = sub_i ? (acc_i - prod) : (acc_i + prod);
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Radix-2 iterative MULT/MADD/MSUB/DIV unit with a start/ready handshake,
// annul path and one sign/accumulate fix-up cycle.
module iter_muldiv
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [WIDTH-1:0]   lo_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         state_reg, state_next;
  logic [2:0]         op_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] work_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               neg_lo_reg, neg_hi_reg;

  logic               sign1, sign2, div0;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [2*WIDTH-1:0] fix_result;

  // Magnitudes are read as unsigned, so the most-negative value maps to 2^(WIDTH-1).
  assign sign1 = is_signed_op(op_i) & opdata1_i[WIDTH-1];
  assign sign2 = is_signed_op(op_i) & opdata2_i[WIDTH-1];
  assign mag1  = sign1 ? (~opdata1_i + ONE_W) : opdata1_i;
  assign mag2  = sign2 ? (~opdata2_i + ONE_W) : opdata2_i;
  assign div0  = is_div(op_i) && (opdata2_i == '0);

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_step = {mul_sum, work_reg[WIDTH-1:1]};

  // Divide: shift left one bit, trial-subtract the divisor from the upper half.
  assign div_trial = work_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};
  assign div_step  = div_trial[WIDTH] ? {work_reg[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .val_i    (work_reg),
    .acc_i    (acc_reg),
    .div_i    (is_div(op_reg)),
    .neg_lo_i (neg_lo_reg),
    .neg_hi_i (neg_hi_reg),
    .acc_en_i (is_acc(op_reg)),
    .sub_i    (is_sub(op_reg)),
    .result_o (fix_result)
  );

  always_comb begin
    state_next = state_reg;
    if (annul_i) begin
      state_next = MD_IDLE;
    end else begin
      case (state_reg)
        MD_IDLE: if (start_i == DIV_START) state_next = div0 ? MD_DONE : MD_CALC;
        MD_CALC: begin
          if (start_i == DIV_STOP)        state_next = MD_IDLE;
          else if (cnt_reg == LAST_STEP)  state_next = MD_FIX;
        end
        MD_FIX:  state_next = (start_i == DIV_STOP) ? MD_IDLE : MD_DONE;
        MD_DONE: if (start_i == DIV_STOP) state_next = MD_IDLE;
        default: state_next = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= MD_IDLE;
      op_reg     <= MD_MULTU;
      cnt_reg    <= '0;
      opnd_reg   <= '0;
      work_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        MD_IDLE: begin
          if (start_i == DIV_START && !annul_i) begin
            op_reg     <= op_i;
            cnt_reg    <= '0;
            acc_reg    <= {hi_i, lo_i};
            neg_lo_reg <= sign1 ^ sign2;
            neg_hi_reg <= sign1;
            if (is_div(op_i)) begin
              work_reg <= {{WIDTH{1'b0}}, mag1};
              opnd_reg <= mag2;
            end else begin
              work_reg <= {{WIDTH{1'b0}}, mag2};
              opnd_reg <= mag1;
            end
            if (div0) result_reg <= {opdata1_i, {WIDTH{1'b1}}};
          end
        end
        MD_CALC: begin
          cnt_reg  <= cnt_reg + CNT_ONE;
          work_reg <= is_div(op_reg) ? div_step : mul_step;
        end
        MD_FIX: begin
          if (state_next == MD_DONE) result_reg <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_reg;
  assign ready_o  = (state_reg == MD_DONE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign busy_o   = (state_reg == MD_CALC) || (state_reg == MD_FIX);

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised, iterative multiply/divide/accumulate unit for the execute stage.
- Generalises the fixed 32-bit divider handshake to any operand width.
- Folds MULT/MULTU, MADD/MADDU, MSUB/MSUBU and DIV/DIVU into one radix-2 multi-cycle datapath with a single start/ready handshake and an annul path.
- Execute stage holds start_i (and stalls the pipeline) until ready_o, then writes result_o to HI/LO.

Parameters:
- WIDTH, 32, operand width in bits; even, >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request; must stay high until ready_o is seen.
- annul_i  in  1  cancel current operation (flush or exception).
- op_i  in  3  operation, sampled at start:
  - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV
  - 100 MADDU, 101 MADD, 110 MSUBU, 111 MSUB
- opdata1_i  in  WIDTH  multiplicand or dividend.
- opdata2_i  in  WIDTH  multiplier or divisor.
- hi_i  in  WIDTH  current HI (accumulate ops), sampled at start.
- lo_i  in  WIDTH  current LO (accumulate ops), sampled at start.
- result_o  out  2*WIDTH  {HI,LO}.
  - Mul ops: full product or accumulated value.
  - Div ops: {remainder, quotient}.
- ready_o  out  1  result valid.
- busy_o  out  1  operation in progress (CALC or FIX).

Behaviour:
- Reset: state IDLE; result_o=0, ready_o=0, busy_o=0; counter and internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 and annul_i=0: latch op_i, operands and {hi_i,lo_i}.
  - op_i[0]=1 (signed): take magnitudes of operands.
  - Counter=0. Go to CALC.
  - Exception: DIV/DIVU with opdata2_i==0 goes directly to DONE with result_o={opdata1_i, all ones}.
- CALC: one radix-2 step per cycle, exactly WIDTH cycles, then FIX.
  - Multiply: shift-add on 2*WIDTH product register.
  - Divide: restoring shift-subtract; quotient bits shifted into LO half, partial remainder in HI half.
- FIX (1 cycle):
  - Signed multiply: negate product if operand signs differ.
  - Signed divide: negate quotient if signs differ; remainder takes dividend's sign.
  - MADD*: result = acc + product. MSUB*: result = acc - product. Both modulo 2^(2*WIDTH).
  - Go to DONE.
- DONE: ready_o=1 and result_o stable while start_i=1; go to IDLE the cycle after start_i falls.
- Latency: start sampled at edge N gives ready_o high from edge N+WIDTH+2. Divide-by-zero gives ready_o from edge N+1.
- busy_o=1 exactly in CALC and FIX. ready_o=1 exactly in DONE.
- start_i dropping during CALC or FIX aborts: next state IDLE, result_o unchanged, no ready_o.
- annul_i=1 in any state: next state IDLE, ready_o=0 next cycle. annul_i wins over a simultaneous start_i.
- No new operation starts from DONE: start_i must be low for at least one cycle first.
- Synchronous rst mid-operation behaves as reset, including from DONE.
- Most-negative signed operands: magnitude computed in WIDTH+1 bits. Examples: MULT of min*min is positive; DIV min/-1 gives quotient=min, remainder=0 (wraps).
- op_i, opdata*_i, hi_i, lo_i are ignored outside IDLE.

Decomposition:
- Shared defines (existing global defines file):
  - op_i encodings: MD_MULTU, MD_MULT, MD_DIVU, MD_DIV, MD_MADDU, MD_MADD, MD_MSUBU, MD_MSUB.
  - State encodings: MD_IDLE, MD_CALC, MD_FIX, MD_DONE.
  - Existing handshake macros reused: DivStart/DivStop, DivResultReady/DivResultNotReady.
- One sub-module: md_sign_fix. Combinational conditional negate of a 2*WIDTH value plus the accumulate add/sub, used in FIX.
- Everything else in a single FSM module.

Test Plan (WIDTH=32 unless stated):
- DIV -7/2 (0xFFFFFFF9, 0x00000002): start held, ready_o at edge N+34, result_o={0xFFFFFFFF, 0xFFFFFFFD}; start dropped gives ready_o=0 next cycle.
- MULT 0xFFFFFFFF*0x00000002: result_o=0xFFFFFFFF_FFFFFFFE; MULTU on the same operands gives 0x00000001_FFFFFFFE.
- MADDU with hi_i=0, lo_i=0xFFFFFFFF, 1*1: result_o=0x00000001_00000000. MSUB with WIDTH=8, acc 0, 3*0xFE: result_o=0x0006.
- DIVU 5/0: ready_o at edge N+1, result_o={0x00000005, 0xFFFFFFFF}, busy_o never asserted.
- annul_i pulsed at CALC cycle 10 of a DIV: busy_o=0 next cycle, ready_o never rises. Next start then completes normally, e.g. DIVU 100/7 gives {2, 14}.
- rst asserted in DONE: ready_o=0 and result_o=0 next cycle. Also start_i low mid-CALC returns to IDLE with no ready_o.
